ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_ctrl.sv | 142 ++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// March-style RAM BIST controller: writes P(a), checks it, writes ~P(a), checks it,
// and reports mismatch count plus the location and phase of the first failure.
module ram_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_phase
);

  localparam int ERR_W = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [ERR_W-1:0]      ONE_E = ERR_W'(1);

  typedef enum logic [2:0] {IDLE, WRITE0, READ0, WRITE1, READ1, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   seed_q, seed_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt, fail_addr_nxt;
  logic                    we_nxt, fail_phase_nxt, pass_nxt;
  logic [DATA_WIDTH-1:0]   din_nxt, exp_word;
  logic [ERR_W-1:0]        err_nxt;

  // Address is zero-extended or truncated to the word width before the seed XOR.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic inv,
                                                     input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] wide;
    logic [DATA_WIDTH-1:0]            word;
    wide = {{DATA_WIDTH{1'b0}}, a};
    word = wide[DATA_WIDTH-1:0] ^ s;
    return inv ? ~word : word;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    seed_nxt       = seed_q;
    addr_nxt       = ram_addr;
    we_nxt         = 1'b0;
    din_nxt        = ram_din;
    err_nxt        = err_cnt;
    pass_nxt       = pass;
    fail_addr_nxt  = fail_addr;
    fail_phase_nxt = fail_phase;
    exp_word       = pattern(ram_addr, state == READ1, seed_q);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = WRITE0;
          seed_nxt       = seed;
          addr_nxt       = '0;
          we_nxt         = 1'b1;
          din_nxt        = pattern('0, 1'b0, seed);
          err_nxt        = '0;
          pass_nxt       = 1'b0;
          fail_addr_nxt  = '0;
          fail_phase_nxt = 1'b0;
        end
      end
      WRITE0, WRITE1: begin
        if (ram_addr == LAST_ADDR) begin
          state_nxt = (state == WRITE0) ? READ0 : READ1;
          addr_nxt  = '0;
        end else begin
          addr_nxt = ram_addr + ONE_A;
          we_nxt   = 1'b1;
          din_nxt  = pattern(ram_addr + ONE_A, state == WRITE1, seed_q);
        end
      end
      READ0, READ1: begin
        // Asynchronous-read RAM: ram_dout reflects ram_addr within this cycle.
        if (ram_dout != exp_word) begin
          err_nxt = err_cnt + ONE_E;
          if (err_cnt == '0) begin
            fail_addr_nxt  = ram_addr;
            fail_phase_nxt = (state == READ1);
          end
        end
        if (ram_addr == LAST_ADDR) begin
          addr_nxt = '0;
          if (state == READ0) begin
            state_nxt = WRITE1;
            we_nxt    = 1'b1;
            din_nxt   = pattern('0, 1'b1, seed_q);
          end else begin
            state_nxt = DONE;
            pass_nxt  = (err_nxt == '0);
          end
        end else begin
          addr_nxt = ram_addr + ONE_A;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q     <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= '0;
      err_cnt    <= '0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_phase <= 1'b0;
    end else begin
      seed_q     <= seed_nxt;
      ram_addr   <= addr_nxt;
      ram_we     <= we_nxt;
      ram_din    <= din_nxt;
      err_cnt    <= err_nxt;
      pass       <= pass_nxt;
      fail_addr  <= fail_addr_nxt;
      fail_phase <= fail_phase_nxt;
    end
  end

  assign busy = (state == WRITE0) || (state == READ0) || (state == WRITE1) || (state == READ1);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: faulty/fault-free RAM model, cycle-position reference
// trace, and a scoreboard of expected test results popped on each done pulse.
module tb_ram_bist_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TEST_CYC = 4 * (1 << AW);

  logic          clk, rst, start;
  logic [DW-1:0] seed;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, done, pass;
  logic [AW+1:0] err_cnt;
  logic [AW-1:0] fail_addr;
  logic          fail_phase;

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_phase(fail_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: mode 0 fault-free, 1 = bit0 of addr 5 stuck-at-0, 2 = addr bit7 tied 0
  logic [1:0]    mode;
  logic [DW-1:0] mem [256];
  logic [AW-1:0] eff_addr;
  assign eff_addr = (mode == 2'd2) ? {1'b0, ram_addr[6:0]} : ram_addr;
  assign ram_dout = mem[eff_addr];
  always @(posedge clk)
    if (ram_we) mem[eff_addr] <= (mode == 2'd1 && eff_addr == 8'd5) ? (ram_din & 8'hFE) : ram_din;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic          pass;
    logic [AW+1:0] err;
    logic [AW-1:0] fa;
    logic          fp;
  } vec_t;

  vec_t vecs [6];
  vec_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference position model: k = edges since the accepting start edge
  int            arm_req = 0, arm_ack = 0;
  int            k = 0;
  bit            tracking = 0;
  logic [DW-1:0] sb_seed;
  int            trace_bad = 0, trace_seen = 0;
  int            done_seen = 0;

  always @(posedge clk) begin
    if (rst) begin
      tracking = 0;
      sb.delete();
    end else if (arm_req != arm_ack || (tracking && k == TEST_CYC + 1 && start)) begin
      arm_ack  = arm_req;
      k        = 0;
      tracking = 1;
    end else if (tracking) begin
      k++;
      if (k > TEST_CYC + 1) tracking = 0;
    end
  end

  always @(negedge clk) begin
    logic          e_busy, e_done, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    vec_t          e;
    if (tracking && !rst) begin
      e_busy = (k < TEST_CYC);
      e_done = (k == TEST_CYC);
      e_we   = (k < 256) || (k >= 512 && k < 768);
      e_addr = AW'(k % 256);
      e_din  = (k < 256) ? (e_addr ^ sb_seed) : ~(e_addr ^ sb_seed);
      if (busy !== e_busy || done !== e_done || ram_we !== e_we ||
          (k < TEST_CYC && ram_addr !== e_addr) || (e_we && ram_din !== e_din)) begin
        if (trace_bad == trace_seen)
          $display("trace deviation k=%0d busy=%b done=%b we=%b addr=%0h din=%0h exp busy=%b done=%b we=%b addr=%0h din=%0h",
                   k, busy, done, ram_we, ram_addr, ram_din, e_busy, e_done, e_we, e_addr, e_din);
        trace_bad++;
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pass", 32'(pass), 32'(e.pass));
        check("err_cnt", 32'(err_cnt), 32'(e.err));
        check("fail_addr", 32'(fail_addr), 32'(e.fa));
        check("fail_phase", 32'(fail_phase), 32'(e.fp));
      end
    end
  end

  task automatic wait_done(input int n0);
    int c;
    for (c = 0; c < 3000 && done_seen == n0; c++) @(negedge clk);
    check("done_timeout", 32'(done_seen != n0), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_fa"}, 32'(fail_addr), 32'd0);
    check({tag, "_fp"}, 32'(fail_phase), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_din"}, 32'(ram_din), 32'd0);
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    mode    = v.mode;
    seed    = v.seed;
    sb_seed = v.seed;
    sb.push_back(v);
    start   = 1'b1;
    arm_req++;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_test(input vec_t v);
    int n0;
    n0 = done_seen;
    launch(v);
    wait_done(n0);
    repeat (3) @(negedge clk);
    check("hold_err_cnt", 32'(err_cnt), 32'(v.err));
    check("hold_pass", 32'(pass), 32'(v.pass));
    check("trace", 32'(trace_bad), 32'(trace_seen));
    trace_seen = trace_bad;
  endtask

  initial begin
    int   c, n0;
    vec_t v;
    vecs[0] = '{mode: 2'd0, seed: 8'h00, pass: 1'b1, err: 10'd0,   fa: 8'h00, fp: 1'b0};
    vecs[1] = '{mode: 2'd0, seed: 8'hFF, pass: 1'b1, err: 10'd0,   fa: 8'h00, fp: 1'b0};
    vecs[2] = '{mode: 2'd1, seed: 8'h00, pass: 1'b0, err: 10'd1,   fa: 8'h05, fp: 1'b0};
    vecs[3] = '{mode: 2'd1, seed: 8'h01, pass: 1'b0, err: 10'd1,   fa: 8'h05, fp: 1'b1};
    vecs[4] = '{mode: 2'd2, seed: 8'hA5, pass: 1'b0, err: 10'd256, fa: 8'h00, fp: 1'b0};
    vecs[5] = '{mode: 2'd0, seed: 8'h5A, pass: 1'b1, err: 10'd0,   fa: 8'h00, fp: 1'b0};

    rst = 1'b1; start = 1'b0; seed = '0; mode = 2'd0; sb_seed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_test(vecs[i]);

    // start while busy must be ignored
    n0 = done_seen;
    launch(vecs[0]);
    repeat (40) @(negedge clk);
    start = 1'b1; seed = 8'h77;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0);
    check("trace_busy_start", 32'(trace_bad), 32'(trace_seen));
    trace_seen = trace_bad;

    // reset in READ0 aborts with no done; then a clean restart
    v = '{mode: 2'd0, seed: 8'h00, pass: 1'b1, err: 10'd0, fa: 8'h00, fp: 1'b0};
    launch(v);
    for (c = 0; c < 2000 && !(tracking && k == 299); c++) @(negedge clk);
    check("reach_e300", 32'(k), 32'd299);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    n0 = done_seen;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 32'(done_seen), 32'(n0));
    run_test('{mode: 2'd0, seed: 8'h3C, pass: 1'b1, err: 10'd0, fa: 8'h00, fp: 1'b0});

    // start held high: three back-to-back tests
    v = '{mode: 2'd0, seed: 8'h11, pass: 1'b1, err: 10'd0, fa: 8'h00, fp: 1'b0};
    n0 = done_seen;
    @(negedge clk);
    seed = v.seed; sb_seed = v.seed; mode = v.mode;
    sb.push_back(v); sb.push_back(v); sb.push_back(v);
    start = 1'b1;
    arm_req++;
    for (int t = 0; t < 3; t++) wait_done(n0 + t);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("held_done_count", 32'(done_seen - n0), 32'd3);
    check("held_busy_idle", 32'(busy), 32'd0);
    check("trace_held", 32'(trace_bad), 32'(trace_seen));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
